regfile_sb: RTL
===============

REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 Parameter WIDTH, default 32: data word width in bits.
REQ-002 Parameter DEPTH, default 32: number of registers, power of two, at least 2.
REQ-003 Parameter AW, default $clog2(DEPTH): register address width.
REQ-004 Parameter ZERO_REG, default 1: when 1, register 0 always reads 0 and ignores writes.
REQ-005 Parameter BYPASS, default 1: when 1, same-cycle write data is forwarded to the read ports.
REQ-006 clk  in  1  sole clock; all state updates on its rising edge.
REQ-007 rst_n  in  1  reset, asynchronous, active-low.
REQ-008 ra  in  AW  read port A address.
REQ-009 rb  in  AW  read port B address.
REQ-010 a  out  WIDTH  read port A data, combinational.
REQ-011 b  out  WIDTH  read port B data, combinational.
REQ-012 we  in  1  write enable (writeback).
REQ-013 rw  in  AW  write address.
REQ-014 w  in  WIDTH  write data.
REQ-015 set_v  in  1  issue of a long-latency producer; marks set_reg pending.
REQ-016 set_reg  in  AW  destination register of the issued producer.
REQ-017 busy_a  out  1  register ra has a pending producer.
REQ-018 busy_b  out  1  register rb has a pending producer.
REQ-019 hazard  out  1  busy_a OR busy_b.
REQ-020 inflight  out  AW+1  count of registers currently marked pending.

Function
REQ-021 Storage: DEPTH x WIDTH data array plus a DEPTH-bit pending (scoreboard) vector.
REQ-022 Write: on a rising edge with we=1, data[rw] takes w, unless ZERO_REG=1 and rw=0, in which case nothing changes.
REQ-023 Read: a = data[ra] and b = data[rb], asynchronous, with zero cycles of latency.
REQ-024 Zero register: with ZERO_REG=1 and address 0, the read port returns 0 regardless of bypass.
REQ-025 Bypass: with BYPASS=1, we=1, rw=ra and the write not suppressed, a = w in the same cycle; port b behaves identically.
REQ-026 No bypass: with BYPASS=0, a read of a register written in the same cycle returns the old value until the next edge.
REQ-027 Scoreboard set: on an edge with set_v=1, pending[set_reg] becomes 1; ignored when ZERO_REG=1 and set_reg=0.
REQ-028 Scoreboard clear: on an edge with we=1, pending[rw] becomes 0.
REQ-029 Set and clear of the same register on the same edge: set wins, so pending stays 1 (new producer).
REQ-030 Set and clear of different registers on the same edge: both take effect.
REQ-031 busy_a = pending[ra], forced to 0 in either of these cases:
- BYPASS=1 and we=1 with rw=ra (the result is being forwarded);
- ZERO_REG=1 and ra=0.
busy_b follows the same rule using rb.
REQ-032 inflight equals the population count of the pending vector. It is maintained as a registered counter updated by:
- +1 for a set of a non-pending register;
- -1 for a clear of a pending register;
- net 0 when both occur, or in the set-wins case of REQ-029.
REQ-033 A set of a register that is already pending leaves inflight unchanged; a clear of a non-pending register leaves it unchanged.
REQ-034 inflight never exceeds DEPTH (DEPTH-1 when ZERO_REG=1) and never underflows.
REQ-035 Writes are accepted regardless of pending state; the scoreboard is advisory only.

Reset
REQ-036 rst_n=0 immediately, without waiting for clk:
- clears every data entry to 0;
- clears the pending vector;
- sets inflight to 0.
REQ-037 During reset: a=0, b=0, busy_a=0, busy_b=0, hazard=0; we and set_v are ignored.
REQ-038 Reset asserted mid-operation, including on an edge with we or set_v active: the reset values win and no write lands.
REQ-039 After rst_n deasserts, the first rising edge performs normal writes and sets.

Verification
REQ-040 Reset then read every address -> a=b=0 for all 32 entries, inflight=0.
REQ-041 Write w=0xDEADBEEF to rw=5, then ra=5 the next cycle -> a=0xDEADBEEF. Same-cycle read of rw=ra=5 with w=0x12345678 -> a=0x12345678 (BYPASS=1), old value (BYPASS=0).
REQ-042 Write 0xFFFFFFFF to rw=0 with ZERO_REG=1, and set_v with set_reg=0 -> a reads 0, busy_a=0, inflight=0.
REQ-043 set_v for regs 3 and 7 on successive edges -> inflight=2, busy_a=1 for ra=3. Then we=1 rw=3 -> busy_a=0 in the same cycle; inflight=1 after the edge.
REQ-044 Edge with set_v=1 set_reg=7 and we=1 rw=7 while 7 is pending -> pending[7] remains 1, inflight unchanged, data[7] updated.
REQ-045 Drop rst_n asynchronously between edges with inflight=2 and data[5]=0xA5A5A5A5 -> immediately a=0 for ra=5 and inflight=0.

Source files
------------

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - register file with write bypass and pending-producer scoreboard
module regfile_sb #(
   parameter int WIDTH    = 32,
   parameter int DEPTH    = 32,
   parameter int AW       = $clog2(DEPTH),
   parameter bit ZERO_REG = 1'b1,
   parameter bit BYPASS   = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [AW-1:0]    ra,
   input  logic [AW-1:0]    rb,
   output logic [WIDTH-1:0] a,
   output logic [WIDTH-1:0] b,
   input  logic             we,
   input  logic [AW-1:0]    rw,
   input  logic [WIDTH-1:0] w,
   input  logic             set_v,
   input  logic [AW-1:0]    set_reg,
   output logic             busy_a,
   output logic             busy_b,
   output logic             hazard,
   output logic [AW:0]      inflight
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [DEPTH-1:0] pending;

   logic set_ok;
   logic wr_ok;
   logic inc;
   logic dec;
   logic fwd_a;
   logic fwd_b;
   logic zero_a;
   logic zero_b;

   assign set_ok = set_v && !(ZERO_REG && set_reg == '0);
   assign wr_ok  = we && !(ZERO_REG && rw == '0);

   // Counter tracks popcount: a same-register set+clear leaves the bit set.
   assign inc = set_ok && !pending[set_reg];
   assign dec = we && pending[rw] && !(set_ok && set_reg == rw);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
         pending  <= '0;
         inflight <= '0;
      end else begin
         if (wr_ok) begin
            mem[rw] <= w;
         end
         if (we) begin
            pending[rw] <= 1'b0;
         end
         if (set_ok) begin
            pending[set_reg] <= 1'b1;
         end
         inflight <= inflight + (AW+1)'(inc) - (AW+1)'(dec);
      end
   end

   // Forwarding is gated by rst_n so the ports read zero while in reset.
   assign fwd_a  = BYPASS && rst_n && we && (rw == ra);
   assign fwd_b  = BYPASS && rst_n && we && (rw == rb);
   assign zero_a = ZERO_REG && (ra == '0);
   assign zero_b = ZERO_REG && (rb == '0);

   assign a = zero_a ? '0 : (fwd_a ? w : mem[ra]);
   assign b = zero_b ? '0 : (fwd_b ? w : mem[rb]);

   assign busy_a = pending[ra] && !fwd_a && !zero_a;
   assign busy_b = pending[rb] && !fwd_b && !zero_b;
   assign hazard = busy_a || busy_b;

endmodule
